wt_mem_responder: RTL and testbench

- Memory-side responder for the write-through D$ memory interface. It is the far end of the dcache data-request / return channel: it accepts load, store and AMO requests from the D$ and returns load, store and AMO acks with matching tid.
- Holds a small zero-initialised backing store, serves requests strictly in order, and adds a programmable fixed latency.
- Used as a synthesizable memory stand-in for cache-only benches and FPGA bring-up in place of the AXI/L15 adapter.

---
 rtl/wt_mem_responder_pkg.sv | 52 +++++
 rtl/wt_mem_resp_fifo.sv | 53 +++++
 rtl/wt_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_wt_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_mem_responder_pkg.sv
`default_nettype none
// wt_mem_responder_pkg: request/return encodings, FIFO entry type and AMO helper for the D$ memory responder.
// Rev 1.0
package wt_mem_responder_pkg;

  // Entry fields are sized for the widest supported configuration; narrower ports zero-extend.
  localparam int unsigned MaxTidWidth   = 8;
  localparam int unsigned MaxPAddrWidth = 64;

  typedef enum logic [1:0] {
    MEM_LOAD   = 2'd0,
    MEM_STORE  = 2'd1,
    MEM_ATOMIC = 2'd2,
    MEM_RSVD   = 2'd3
  } mem_rtype_e;

  typedef enum logic [1:0] {
    RTRN_LOAD_ACK   = 2'd0,
    RTRN_STORE_ACK  = 2'd1,
    RTRN_ATOMIC_ACK = 2'd2
  } rtrn_type_e;

  typedef enum logic [1:0] {
    AMO_SWAP = 2'd0,
    AMO_ADD  = 2'd1,
    AMO_AND  = 2'd2,
    AMO_OR   = 2'd3
  } amo_op_e;

  typedef struct packed {
    mem_rtype_e               rtype;
    logic [MaxTidWidth-1:0]   tid;
    logic [MaxPAddrWidth-1:0] paddr;
    logic [63:0]              data;
    logic [7:0]               be;
    amo_op_e                  amo_op;
  } mem_req_t;

  function automatic logic [63:0] amo_compute(amo_op_e op, logic [63:0] old_val,
                                              logic [63:0] operand);
    logic [63:0] res;
    case (op)
      AMO_SWAP: res = operand;
      AMO_ADD:  res = old_val + operand;
      AMO_AND:  res = old_val & operand;
      default:  res = old_val | operand;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wt_mem_resp_fifo.sv
`default_nettype none
// wt_mem_resp_fifo: register FIFO of pending memory requests with full/empty flags and occupancy.
// Rev 1.0
module wt_mem_resp_fifo
  import wt_mem_responder_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  mem_req_t                 data_i,
  input  logic                     pop_i,
  output mem_req_t                 data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  mem_req_t        slot_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = slot_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Payload storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) slot_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/wt_mem_responder.sv
`default_nettype none
// wt_mem_responder: in-order, fixed-latency memory responder for the write-through D$ data channel.
// Rev 1.0
module wt_mem_responder
  import wt_mem_responder_pkg::*;
#(
  parameter int unsigned LineWidth  = 128,
  parameter int unsigned MemWords   = 1024,
  parameter int unsigned Latency    = 2,
  parameter int unsigned FifoDepth  = 4,
  parameter int unsigned TidWidth   = 2,
  parameter int unsigned PAddrWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  busy_o,
  input  logic                  mem_data_req_i,
  output logic                  mem_data_ack_o,
  input  logic [1:0]            mem_rtype_i,
  input  logic [TidWidth-1:0]   mem_tid_i,
  input  logic [PAddrWidth-1:0] mem_paddr_i,
  input  logic [63:0]           mem_data_i,
  input  logic [7:0]            mem_be_i,
  input  logic [1:0]            mem_amo_op_i,
  output logic                  mem_rtrn_vld_o,
  output logic [1:0]            mem_rtrn_type_o,
  output logic [TidWidth-1:0]   mem_rtrn_tid_o,
  output logic [LineWidth-1:0]  mem_rtrn_data_o
);

  localparam int unsigned WordsPerLine = LineWidth / 64;
  localparam int unsigned WIdxW        = $clog2(MemWords);
  localparam int unsigned CntW         = $clog2(FifoDepth) + 1;
  localparam int unsigned LatW         = $clog2(Latency) + 1;
  localparam logic [WIdxW-1:0] LineMask = ~WIdxW'(WordsPerLine - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_EXEC} state_e;

  state_e               state_q;
  logic [WIdxW-1:0]     clr_ptr_q;
  logic [LatW-1:0]      lat_cnt_q;
  logic                 rtrn_vld_q;
  rtrn_type_e           rtrn_type_q;
  logic [TidWidth-1:0]  rtrn_tid_q;
  logic [LineWidth-1:0] rtrn_data_q;
  logic [63:0]          mem_q [MemWords];

  mem_req_t             req_in, head;
  logic                 fifo_full, fifo_empty, pop;
  logic [CntW-1:0]      fifo_cnt;
  logic                 unused_head;

  logic [WIdxW-1:0]     widx, lbase, mem_waddr;
  logic [63:0]          old_word, wr_word_d, mem_wdata;
  logic [LineWidth-1:0] line_rd, slot_old, rtrn_data_d;
  rtrn_type_e           rtrn_type_d;
  logic                 exec_we, mem_we;

  assign busy_o          = (state_q == S_INIT);
  assign mem_data_ack_o  = mem_data_req_i & ~fifo_full & (state_q != S_INIT);
  assign pop             = (state_q == S_EXEC);
  assign mem_rtrn_vld_o  = rtrn_vld_q;
  assign mem_rtrn_type_o = rtrn_type_q;
  assign mem_rtrn_tid_o  = rtrn_tid_q;
  assign mem_rtrn_data_o = rtrn_data_q;

  assign req_in = '{rtype:  mem_rtype_e'(mem_rtype_i),
                    tid:    MaxTidWidth'(mem_tid_i),
                    paddr:  MaxPAddrWidth'(mem_paddr_i),
                    data:   mem_data_i,
                    be:     mem_be_i,
                    amo_op: amo_op_e'(mem_amo_op_i)};

  wt_mem_resp_fifo #(.Depth(FifoDepth)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (mem_data_ack_o),
    .data_i  (req_in),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Upper address bits wrap; only the word index selects storage.
  assign widx        = head.paddr[WIdxW+2:3];
  assign lbase       = widx & LineMask;
  assign old_word    = mem_q[widx];
  assign unused_head = ^head;

  always_comb begin
    line_rd  = '0;
    slot_old = '0;
    for (int k = 0; k < WordsPerLine; k++) begin
      line_rd[64*k +: 64] = mem_q[lbase | WIdxW'(k)];
      if ((lbase | WIdxW'(k)) == widx) slot_old[64*k +: 64] = old_word;
    end
  end

  always_comb begin
    rtrn_type_d = RTRN_STORE_ACK;
    rtrn_data_d = '0;
    wr_word_d   = old_word;
    exec_we     = 1'b0;
    case (head.rtype)
      MEM_LOAD: begin
        rtrn_type_d = RTRN_LOAD_ACK;
        rtrn_data_d = line_rd;
      end
      MEM_STORE: begin
        exec_we = 1'b1;
        for (int b = 0; b < 8; b++) begin
          if (head.be[b]) wr_word_d[8*b +: 8] = head.data[8*b +: 8];
        end
      end
      MEM_ATOMIC: begin
        exec_we     = 1'b1;
        wr_word_d   = amo_compute(head.amo_op, old_word, head.data);
        rtrn_type_d = RTRN_ATOMIC_ACK;
        rtrn_data_d = slot_old;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = widx;
    mem_wdata = wr_word_d;
    if (state_q == S_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
    end else if (state_q == S_EXEC) begin
      mem_we = exec_we;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_INIT;
      clr_ptr_q   <= '0;
      lat_cnt_q   <= '0;
      rtrn_vld_q  <= 1'b0;
      rtrn_type_q <= RTRN_LOAD_ACK;
      rtrn_tid_q  <= '0;
      rtrn_data_q <= '0;
    end else begin
      rtrn_vld_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          clr_ptr_q <= clr_ptr_q + WIdxW'(1);
          if (clr_ptr_q == WIdxW'(MemWords - 1)) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (!fifo_empty) begin
            lat_cnt_q <= LatW'(Latency - 1);
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt_q == '0) state_q <= S_EXEC;
          else                 lat_cnt_q <= lat_cnt_q - LatW'(1);
        end
        default: begin
          rtrn_vld_q  <= 1'b1;
          rtrn_type_q <= rtrn_type_d;
          rtrn_tid_q  <= head.tid[TidWidth-1:0];
          rtrn_data_q <= rtrn_data_d;
          // Occupancy after this pop decides whether the next head starts its wait now.
          if (fifo_cnt > CntW'(1) || mem_data_ack_o) begin
            lat_cnt_q <= LatW'(Latency - 1);
            state_q   <= S_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wt_mem_responder.sv
`default_nettype none
// tb_wt_mem_responder: directed table, back-pressure, reset and random traffic checked against a word-array model.
module tb_wt_mem_responder;

  localparam int LINEW = 128;
  localparam int MEMW  = 1024;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int TIDW  = 2;
  localparam int PAW   = 32;
  localparam int WPL   = LINEW / 64;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             busy, req, ack, r_vld;
  logic [1:0]       m_rtype, m_op, r_type;
  logic [TIDW-1:0]  m_tid, r_tid;
  logic [PAW-1:0]   m_paddr;
  logic [63:0]      m_data;
  logic [7:0]       m_be;
  logic [LINEW-1:0] r_data;

  always #5 clk = ~clk;

  wt_mem_responder #(
    .LineWidth(LINEW), .MemWords(MEMW), .Latency(LAT),
    .FifoDepth(DEPTH), .TidWidth(TIDW), .PAddrWidth(PAW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .busy_o(busy),
    .mem_data_req_i(req), .mem_data_ack_o(ack), .mem_rtype_i(m_rtype),
    .mem_tid_i(m_tid), .mem_paddr_i(m_paddr), .mem_data_i(m_data),
    .mem_be_i(m_be), .mem_amo_op_i(m_op), .mem_rtrn_vld_o(r_vld),
    .mem_rtrn_type_o(r_type), .mem_rtrn_tid_o(r_tid), .mem_rtrn_data_o(r_data)
  );

  typedef struct {
    logic [1:0]       typ;
    logic [TIDW-1:0]  tid;
    logic [LINEW-1:0] data;
    int               acc;
  } exp_t;

  typedef struct {
    logic [1:0]       rt;
    logic [TIDW-1:0]  tid;
    logic [31:0]      pa;
    logic [63:0]      d;
    logic [7:0]       be;
    logic [1:0]       op;
    logic [1:0]       etyp;
    logic [LINEW-1:0] edata;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] mdl [MEMW];
  int          errors = 0, checks = 0, cyc = 0, n_rtrn = 0, last_lat = 0;
  int          rtrn_cyc_log [int];
  vec_t        tbl [13];

  always @(posedge clk) cyc <= cyc + 1;

  // Return monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_ni && r_vld) begin
      rtrn_cyc_log[n_rtrn] = cyc;
      n_rtrn++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rtrn_unexpected: got type=%0d tid=%0d data=%h, required no return", r_type, r_tid, r_data);
      end else begin
        mon_e    = sb.pop_front();
        last_lat = cyc - mon_e.acc;
        if (r_type !== mon_e.typ || r_tid !== mon_e.tid || r_data !== mon_e.data) begin
          errors++;
          $display("FAIL rtrn: got type=%0d tid=%0d data=%h, required type=%0d tid=%0d data=%h",
                   r_type, r_tid, r_data, mon_e.typ, mon_e.tid, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [LINEW-1:0] got, input logic [LINEW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < MEMW; i++) mdl[i] = '0;
  endfunction

  // Word-granular memory applied in acceptance order, which equals execution order.
  function automatic exp_t model(input logic [1:0] rt, input logic [TIDW-1:0] tid, input logic [31:0] pa,
                                 input logic [63:0] d, input logic [7:0] be, input logic [1:0] op);
    exp_t        e;
    int          idx, base;
    logic [63:0] old;
    idx    = int'((pa >> 3) % MEMW);
    base   = idx - (idx % WPL);
    e.tid  = tid;
    e.data = '0;
    e.typ  = 2'd1;
    e.acc  = 0;
    case (rt)
      2'd0: begin
        e.typ = 2'd0;
        for (int k = 0; k < WPL; k++) e.data[64*k +: 64] = mdl[base + k];
      end
      2'd1: for (int b = 0; b < 8; b++) if (be[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
      2'd2: begin
        old = mdl[idx];
        case (op)
          2'd0:    mdl[idx] = d;
          2'd1:    mdl[idx] = old + d;
          2'd2:    mdl[idx] = old & d;
          default: mdl[idx] = old | d;
        endcase
        e.typ = 2'd2;
        e.data[64*(idx - base) +: 64] = old;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic send(input logic [1:0] rt, input logic [TIDW-1:0] tid, input logic [31:0] pa,
                      input logic [63:0] d, input logic [7:0] be, input logic [1:0] op,
                      input logic use_tbl, input logic [1:0] etyp, input logic [LINEW-1:0] edata,
                      output int acc_neg);
    int   w;
    exp_t e;
    req = 1'b1; m_rtype = rt; m_tid = tid; m_paddr = pa; m_data = d; m_be = be; m_op = op;
    #1;
    w = 0;
    while (!ack && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    acc_neg = cyc;
    if (!ack) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ack=0 after %0d cycles, required ack=1", w);
      req = 1'b0;
      return;
    end
    e = model(rt, tid, pa, d, be, op);
    if (use_tbl) begin
      e.typ  = etyp;
      e.data = edata;
    end
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_outstanding", LINEW'(sb.size()), '0);
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  // Holds a request during the clear sweep; it must never be acked there.
  task automatic check_init(input string tag);
    int n = 0, acks = 0;
    req = 1'b1; m_rtype = 2'd0; m_paddr = '0; m_tid = '0;
    #1;
    while (busy && n < 5000) begin
      if (ack) acks++;
      n++;
      @(negedge clk);
      #1;
    end
    req = 1'b0;
    chk({tag, "_busy_cycles"}, LINEW'(n), LINEW'(MEMW));
    chk({tag, "_ack_in_init"}, LINEW'(acks), '0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dummy, n0;
    int accs [6];
    logic [1:0]  rt, op;
    logic [31:0] pa;

    tbl[0]  = '{2'd1, 2'd2, 32'h48,   64'h1122334455667788, 8'h0F, 2'd0, 2'd1, 128'h0};
    tbl[1]  = '{2'd0, 2'd3, 32'h40,   64'h0,                8'h00, 2'd0, 2'd0, 128'h0000000055667788_0000000000000000};
    tbl[2]  = '{2'd1, 2'd0, 32'h8,    64'hFFFFFFFFFFFFFFFE, 8'hFF, 2'd0, 2'd1, 128'h0};
    tbl[3]  = '{2'd2, 2'd1, 32'h8,    64'd5,                8'h00, 2'd1, 2'd2, 128'hFFFFFFFFFFFFFFFE_0000000000000000};
    tbl[4]  = '{2'd0, 2'd2, 32'h0,    64'h0,                8'h00, 2'd0, 2'd0, 128'h0000000000000003_0000000000000000};
    tbl[5]  = '{2'd1, 2'd3, 32'h2000, 64'hDEADBEEFCAFEF00D, 8'hFF, 2'd0, 2'd1, 128'h0};
    tbl[6]  = '{2'd0, 2'd0, 32'h0,    64'h0,                8'h00, 2'd0, 2'd0, 128'h0000000000000003_DEADBEEFCAFEF00D};
    tbl[7]  = '{2'd3, 2'd1, 32'h10,   64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'd0, 2'd1, 128'h0};
    tbl[8]  = '{2'd1, 2'd2, 32'h10,   64'hFFFFFFFFFFFFFFFF, 8'h00, 2'd0, 2'd1, 128'h0};
    tbl[9]  = '{2'd2, 2'd3, 32'h10,   64'hA5A5,             8'h00, 2'd0, 2'd2, 128'h0};
    tbl[10] = '{2'd2, 2'd0, 32'h18,   64'hF0,               8'h00, 2'd3, 2'd2, 128'h0};
    tbl[11] = '{2'd2, 2'd1, 32'h18,   64'h30,               8'h00, 2'd2, 2'd2, 128'h00000000000000F0_0000000000000000};
    tbl[12] = '{2'd0, 2'd2, 32'h10,   64'h0,                8'h00, 2'd0, 2'd0, 128'h0000000000000030_000000000000A5A5};

    req = 1'b0; m_rtype = '0; m_tid = '0; m_paddr = '0; m_data = '0; m_be = '0; m_op = '0;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", LINEW'(busy), 1);
    chk("rst_ack", LINEW'(ack), 0);
    chk("rst_vld", LINEW'(r_vld), 0);
    chk("rst_type", LINEW'(r_type), 0);
    chk("rst_tid", LINEW'(r_tid), 0);
    chk("rst_data", r_data, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    check_init("init");

    send(2'd0, 2'd1, 32'h40, 64'h0, 8'h0, 2'd0, 1'b0, 2'd0, '0, dummy);
    drain();
    chk("first_load_latency", LINEW'(last_lat), LINEW'(LAT + 2));

    foreach (tbl[i])
      send(tbl[i].rt, tbl[i].tid, tbl[i].pa, tbl[i].d, tbl[i].be, tbl[i].op,
           1'b1, tbl[i].etyp, tbl[i].edata, dummy);
    drain();

    // Six back-to-back loads into a four-deep FIFO: the fifth waits for the first pop.
    n0 = n_rtrn;
    for (int i = 0; i < 6; i++)
      send(2'd0, TIDW'(i % 4), 32'(i * 64), 64'h0, 8'h0, 2'd0, 1'b0, 2'd0, '0, accs[i]);
    chk("fifo_fill_b2b", LINEW'(accs[3] - accs[0]), 3);
    chk("fifo_full_stall", LINEW'(accs[4] - accs[3]), 2);
    chk("fifo_accept_at_pop", LINEW'(accs[4]), LINEW'(rtrn_cyc_log.exists(n0) ? rtrn_cyc_log[n0] : -1));
    drain();

    for (int i = 0; i < 300; i++) begin
      rt = 2'($urandom_range(0, 3));
      op = 2'($urandom_range(0, 3));
      pa = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 31)) << 3) | 32'($urandom_range(0, 7));
      send(rt, TIDW'($urandom_range(0, 3)), pa, {$urandom, $urandom}, 8'($urandom), op,
           1'b0, 2'd0, '0, dummy);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Reset while the head is still waiting: nothing queued may ever return.
    for (int i = 0; i < 3; i++)
      send(2'd1, TIDW'(i), 32'h100, 64'h0123456789ABCDEF, 8'hFF, 2'd0, 1'b0, 2'd0, '0, dummy);
    n0 = n_rtrn;
    rst_ni = 1'b0;
    sb.delete();
    model_clear();
    #1;
    chk("midrst_busy", LINEW'(busy), 1);
    chk("midrst_vld", LINEW'(r_vld), 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    check_init("reinit");
    chk("midrst_no_returns", LINEW'(n_rtrn - n0), 0);
    send(2'd0, 2'd3, 32'h100, 64'h0, 8'h0, 2'd0, 1'b0, 2'd0, '0, dummy);
    drain();
    chk("post_reset_latency", LINEW'(last_lat), LINEW'(LAT + 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
